store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer sitting directly upstream of the data memory (DataMem) in the memory-access stage.
- Accepts load/store requests from the pipeline and queues stores in a small FIFO.
- Drains queued stores into DataMem whenever the memory port is free, and forwards buffered store data to younger loads to the same address.
- Loads that miss the buffer read DataMem and return data one cycle later.

Parameters:
- DEPTH, 4, number of store entries (power of two, at least 2).
- ADDR_W, 6, word address width; matches DataMem addr.
- DATA_W, 32, data width; matches DataMem data_in/data_out.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  request accepted on this edge if req_valid is also 1.
- drain_hold  in  1  1 = suppress draining (fence/test control).
- rsp_valid  out  1  load data valid (registered).
- rsp_rdata  out  DATA_W  load data (registered).
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- mem_read  out  1  to DataMem MemRead.
- mem_write  out  1  to DataMem MemWrite.
- mem_addr  out  ADDR_W  to DataMem addr.
- mem_wdata  out  DATA_W  to DataMem data_in.
- mem_rdata  in  DATA_W  from DataMem data_out; combinational in mem_addr when mem_read=1.

Behaviour:
- Reset (async, immediate):
  - Pointers and count cleared to 0; all buffered stores are discarded.
  - rsp_valid=0, rsp_rdata=0.
  - mem_read=0 and mem_write=0 while rst=1.
- FIFO:
  - Head and tail pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- req_ready:
  - Store: ready = !full.
  - Load: ready = !(full && !drain_hold). When full and draining, the drain takes the port and the load stalls.
- Store accepted at edge k:
  - Written at the tail; count increments.
  - Eligible for draining from the cycle after edge k.
  - No coalescing: duplicate addresses occupy separate entries.
- Load accepted:
  - Compare req_addr against all valid entries. The newest match wins (search from tail-1 back to head).
  - Hit: rsp_rdata <= matching entry data, rsp_valid <= 1 at the same edge. DataMem is not accessed (mem_read=0).
  - Miss: in the request cycle drive mem_read=1 and mem_addr=req_addr. At the edge, rsp_rdata <= mem_rdata and rsp_valid <= 1.
  - Load latency is 1 cycle in both cases.
- rsp_valid is 0 in any cycle that follows an edge with no accepted load. rsp_rdata holds its last value.
- Drain (combinational port drive):
  - Occurs when !empty && !drain_hold && the port is not used by a load miss this cycle.
  - Drives mem_write=1, mem_addr=head.addr, mem_wdata=head.data. At the edge, head advances and count decrements.
  - Load hits do not use the port, so a drain may proceed in the same cycle; forwarding sees pre-pop contents.
- Priority on the memory port: load miss over drain, except when full with drain_hold=0, where the drain wins and the load is stalled via req_ready.
- A store enqueue and a drain pop in the same cycle leave count unchanged.
- Port idle (no drain, no load miss): mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- mem_read and mem_write are never both 1 in the same cycle.
- Address arithmetic: no translation; addresses are passed through at ADDR_W bits.

Decomposition:
- Shared package/header mem_pkg holds:
  - ADDR_W and DATA_W defaults (shared with DataMem).
  - SB_DEPTH.
  - The entry record {addr, data}.
- Sub-module store_buffer_fifo contains:
  - Storage array, head/tail/count, push/pop.
  - Parallel read-out of all entries plus per-entry valid bits for the forwarding match.
- Top level contains the newest-match priority logic, port arbitration and the response register.

Test Plan:
1. Reset, then store addr=0 data=39 with drain_hold=0.
   - Next cycle: mem_write=1, mem_addr=0, mem_wdata=39.
   - After the following edge: DataMem[0]=39 and count=0.
2. drain_hold=1; store addr=1 data=22; then load addr=1.
   - mem_read stays 0.
   - Next cycle: rsp_valid=1, rsp_rdata=22.
3. DataMem[2]=53 preloaded, buffer empty; load addr=2.
   - Same cycle: mem_read=1, mem_addr=2.
   - Next cycle: rsp_valid=1, rsp_rdata=53.
4. drain_hold=1; stores to addrs 3,4,5,6 with data 1..4.
   - count=4; a 5th store sees req_ready=0.
   - Release hold: four consecutive writes in order 3,4,5,6, then count=0.
5. drain_hold=1; store addr=5 data=10, then addr=5 data=20; load addr=5.
   - rsp_rdata=20.
   - After release: two writes to addr 5, final DataMem[5]=20.
6. Two stores buffered; assert rst in the middle of a cycle while mem_write=1.
   - mem_write drops immediately and count=0.
   - No further writes after rst is released; DataMem keeps its prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-stage constants and the store-buffer entry record.
// DataMem and the store buffer take their default widths from here.
package mem_pkg;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Store-entry FIFO: circular storage with push/pop and an age-ordered parallel
// read-out (index 0 = oldest) so the top can pick the newest matching entry.
module store_buffer_fifo #(
  parameter int unsigned DEPTH  = mem_pkg::SB_DEPTH,
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [ADDR_W-1:0]              i_push_addr,
  input  logic [DATA_W-1:0]              i_push_data,
  input  logic                           i_pop,
  output logic [ADDR_W-1:0]              o_head_addr,
  output logic [DATA_W-1:0]              o_head_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   o_ent_data,
  output logic [DEPTH-1:0]               o_ent_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  end

  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign o_ent_addr[g]  = r_addr[r_head + PW'(g)];
    assign o_ent_data[g]  = r_data[r_head + PW'(g)];
    assign o_ent_valid[g] = (CW'(g) < r_count);
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of DataMem: queues stores, drains them when the
// port is free and forwards the newest buffered store data to younger loads.
module store_buffer #(
  parameter int unsigned DEPTH  = mem_pkg::SB_DEPTH,
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       req_ready,
  input  logic                       drain_hold,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  logic                         w_full;
  logic                         w_empty;
  logic [ADDR_W-1:0]            w_head_addr;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] w_ent_data;
  logic [DEPTH-1:0]             w_ent_valid;
  logic                         w_hit;
  logic [DATA_W-1:0]            w_hit_data;
  logic                         w_load_acc;
  logic                         w_store_acc;
  logic                         w_load_miss;
  logic                         w_drain;

  store_buffer_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_store_acc),
    .i_push_addr (req_addr),
    .i_push_data (req_wdata),
    .i_pop       (w_drain),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ent_addr  (w_ent_addr),
    .o_ent_data  (w_ent_data),
    .o_ent_valid (w_ent_valid)
  );

  // Entries are age-ordered, so the last match in the scan is the newest store.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_addr[i] == req_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = w_ent_data[i];
      end
    end
  end

  // A full buffer with draining enabled gives the port to the drain.
  assign req_ready   = req_write ? !w_full : !(w_full && !drain_hold);
  assign w_load_acc  = req_valid && !req_write && req_ready;
  assign w_store_acc = req_valid && req_write && req_ready;
  assign w_load_miss = w_load_acc && !w_hit;
  assign w_drain     = !w_empty && !drain_hold && !w_load_miss && !rst;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (w_load_miss) begin
        mem_read = 1'b1;
        mem_addr = req_addr;
      end else if (w_drain) begin
        mem_write = 1'b1;
        mem_addr  = w_head_addr;
        mem_wdata = w_head_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= w_load_acc;
      if (w_load_acc) rsp_rdata <= w_hit ? w_hit_data : mem_rdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural DataMem; expected loads and
// memory writes are queued at issue and checked by an independent monitor.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        drain_hold;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  count;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem [64];

  mem_pkg::sb_entry_t exp_wr [$];
  logic [31:0]        exp_rsp [$];

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .drain_hold (drain_hold),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .count      (count),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? dmem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: checks every response and every DataMem write against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      check("port_exclusive", {31'd0, mem_read && mem_write}, 32'd0);
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
        end
      end
      if (mem_write) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {26'd0, mem_addr}, 32'hffff_ffff);
        end else begin
          mem_pkg::sb_entry_t e;
          e = exp_wr.pop_front();
          check("write_addr", {26'd0, mem_addr}, {26'd0, e.addr});
          check("write_data", mem_wdata, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [5:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    rst        = 1'b1;
    drain_hold = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    repeat (2) step();
    @(negedge clk);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: single store drains the cycle after it is accepted.
    drive(1'b1, 1'b1, 6'd0, 32'd39);
    exp_wr.push_back('{addr: 6'd0, data: 32'd39});
    @(negedge clk);
    check("t1_ready", {31'd0, req_ready}, 32'd1);
    check("t1_no_early_write", {31'd0, mem_write}, 32'd0);
    step();
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    check("t1_count_mid", {29'd0, count}, 32'd1);
    step();
    check("t1_dmem0", dmem[0], 32'd39);
    check("t1_count", {29'd0, count}, 32'd0);

    // 2: forwarding from a held store, no DataMem read.
    drain_hold = 1'b1;
    drive(1'b1, 1'b1, 6'd1, 32'd22);
    step();
    drive(1'b1, 1'b0, 6'd1, 32'd0);
    exp_rsp.push_back(32'd22);
    @(negedge clk);
    check("t2_mem_read", {31'd0, mem_read}, 32'd0);
    check("t2_ready", {31'd0, req_ready}, 32'd1);
    step();
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    check("t2_count", {29'd0, count}, 32'd1);
    step();
    exp_wr.push_back('{addr: 6'd1, data: 32'd22});
    drain_hold = 1'b0;
    step();
    check("t2_count_drained", {29'd0, count}, 32'd0);

    // 3: load miss reads DataMem combinationally.
    dmem[2] = 32'd53;
    drive(1'b1, 1'b0, 6'd2, 32'd0);
    exp_rsp.push_back(32'd53);
    @(negedge clk);
    check("t3_mem_read", {31'd0, mem_read}, 32'd1);
    check("t3_mem_addr", {26'd0, mem_addr}, 32'd2);
    step();
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    step();

    // 4: fill to full, store and load stall, then four back-to-back drains.
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 6'(3 + i), 32'(i + 1));
      step();
    end
    check("t4_count_full", {29'd0, count}, 32'd4);
    drive(1'b1, 1'b1, 6'd7, 32'd5);
    @(negedge clk);
    check("t4_store_stall", {31'd0, req_ready}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) exp_wr.push_back('{addr: 6'(3 + i), data: 32'(i + 1)});
    drive(1'b1, 1'b0, 6'd9, 32'd0);
    drain_hold = 1'b0;
    @(negedge clk);
    check("t4_load_stall", {31'd0, req_ready}, 32'd0);
    check("t4_drain0", {31'd0, mem_write}, 32'd1);
    step();
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("t4_drain_consec", {31'd0, mem_write}, 32'd1);
      step();
    end
    check("t4_count_empty", {29'd0, count}, 32'd0);

    // 5: duplicate addresses; newest wins on forward, both drain in order.
    drain_hold = 1'b1;
    drive(1'b1, 1'b1, 6'd5, 32'd10);
    step();
    drive(1'b1, 1'b1, 6'd5, 32'd20);
    step();
    drive(1'b1, 1'b0, 6'd5, 32'd0);
    exp_rsp.push_back(32'd20);
    @(negedge clk);
    check("t5_mem_read", {31'd0, mem_read}, 32'd0);
    step();
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    check("t5_count", {29'd0, count}, 32'd2);
    exp_wr.push_back('{addr: 6'd5, data: 32'd10});
    exp_wr.push_back('{addr: 6'd5, data: 32'd20});
    drain_hold = 1'b0;
    repeat (2) step();
    check("t5_dmem5", dmem[5], 32'd20);
    check("t5_count_empty", {29'd0, count}, 32'd0);

    // 6: async reset mid-drain discards the buffer.
    drain_hold = 1'b1;
    drive(1'b1, 1'b1, 6'd7, 32'd70);
    step();
    drive(1'b1, 1'b1, 6'd8, 32'd80);
    step();
    drive(1'b0, 1'b0, 6'd0, 32'd0);
    exp_wr.push_back('{addr: 6'd7, data: 32'd70});
    drain_hold = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_write_drop", {31'd0, mem_write}, 32'd0);
    check("t6_count_clear", {29'd0, count}, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    check("t6_dmem7", dmem[7], 32'd0);
    check("t6_dmem8", dmem[8], 32'd0);
    check("t6_dmem0_kept", dmem[0], 32'd39);
    check("t6_count", {29'd0, count}, 32'd0);

    check("pending_writes", exp_wr.size(), 32'd0);
    check("pending_rsps", exp_rsp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
